// File: rtl/reg_sbf_mon.sv
// Single-bit-flip monitor for a load-enabled register: per-lane even parity with sticky status,
// first-failing-lane capture and a saturating event counter. Optional REG_SBF_INJECT_EN adds inj_i.
module reg_sbf_mon #(
    parameter int IN_WIDTH  = 32,
    parameter int N_LANES   = 4,
    parameter int CNT_WIDTH = 8,
    localparam int LANE_W   = IN_WIDTH / N_LANES,
    localparam int LIW      = (N_LANES > 1) ? $clog2(N_LANES) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 en_i,
    input  logic                 we_i,
    input  logic [IN_WIDTH-1:0]  regi_i,
    input  logic [IN_WIDTH-1:0]  rego_i,
    input  logic                 clr_i,
`ifdef REG_SBF_INJECT_EN
    input  logic [N_LANES-1:0]   inj_i,
`endif
    output logic                 error_o,
    output logic [N_LANES-1:0]   lane_err_o,
    output logic                 sticky_o,
    output logic [LIW-1:0]       first_lane_o,
    output logic [CNT_WIDTH-1:0] err_cnt_o
);

    typedef enum logic [1:0] {S_INIT, S_MON, S_ERR} state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_valid;
    logic [N_LANES-1:0]    r_par;
    logic                  r_err_d;
    logic [LIW-1:0]        r_first;
    logic [CNT_WIDTH-1:0]  r_cnt;
    logic [N_LANES-1:0]    w_inj;
    logic [N_LANES-1:0]    w_mismatch;
    logic                  w_event;
    logic                  w_capture;

    function automatic logic [N_LANES-1:0] lane_parity(input logic [IN_WIDTH-1:0] v);
        logic [N_LANES-1:0] p;
        p = '0;
        for (int k = 0; k < N_LANES; k++) begin
            p[k] = ^v[k*LANE_W +: LANE_W];
        end
        return p;
    endfunction

    function automatic logic [LIW-1:0] lowest_lane(input logic [N_LANES-1:0] m);
        logic [LIW-1:0] idx;
        idx = '0;
        for (int k = N_LANES - 1; k >= 0; k--) begin
            if (m[k]) idx = LIW'(k);
        end
        return idx;
    endfunction

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + CNT_WIDTH'(1);
    endfunction

`ifdef REG_SBF_INJECT_EN
    assign w_inj = inj_i;
`else
    assign w_inj = '0;
`endif

    // Parity capture follows the monitored register's load, regardless of enable or state
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_par   <= '0;
            r_valid <= 1'b0;
        end else if (we_i) begin
            r_par   <= lane_parity(regi_i) ^ w_inj;
            r_valid <= 1'b1;
        end
    end

    assign w_mismatch = {N_LANES{r_valid & en_i}} & (lane_parity(rego_i) ^ r_par);
    assign lane_err_o = w_mismatch;
    assign error_o    = |w_mismatch;
    assign w_event    = error_o & ~r_err_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_INIT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_INIT:  if (we_i) w_state_nxt = S_MON;
            S_MON:   if (error_o) w_state_nxt = S_ERR;
            S_ERR:   if (clr_i && !error_o) w_state_nxt = S_MON;
            default: w_state_nxt = S_INIT;
        endcase
    end

    always_comb begin
        sticky_o = (r_state == S_ERR);
    end

    // A clear that coincides with a live error re-arms the capture instead of zeroing it
    assign w_capture = error_o & ((r_state != S_ERR) | clr_i);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_err_d <= 1'b0;
            r_first <= '0;
            r_cnt   <= '0;
        end else begin
            r_err_d <= error_o;
            if (w_capture) begin
                r_first <= lowest_lane(w_mismatch);
            end else if (clr_i) begin
                r_first <= '0;
            end
            if (clr_i) begin
                r_cnt <= w_event ? CNT_WIDTH'(1) : '0;
            end else if (w_event) begin
                r_cnt <= sat_inc(r_cnt);
            end
        end
    end

    assign first_lane_o = r_first;
    assign err_cnt_o    = r_cnt;

endmodule

// File: tb/tb_reg_sbf_mon.sv
// Randomized and directed bench for reg_sbf_mon against a rule-level reference model.
module tb_reg_sbf_mon;
    localparam int IW   = 32;
    localparam int NL   = 4;
    localparam int CW   = 2;
    localparam int LW   = IW / NL;
    localparam int LIW  = 2;
    localparam int CMAX = (1 << CW) - 1;

    logic            clk = 1'b0;
    logic            rst, en, we, clr;
    logic [IW-1:0]   regi, rego;
    logic [NL-1:0]   inj;
    logic            error_o, sticky_o;
    logic [NL-1:0]   lane_err_o;
    logic [LIW-1:0]  first_lane_o;
    logic [CW-1:0]   err_cnt_o;

    reg_sbf_mon #(.IN_WIDTH(IW), .N_LANES(NL), .CNT_WIDTH(CW)) dut (
        .clk_i(clk), .rst_i(rst), .en_i(en), .we_i(we),
        .regi_i(regi), .rego_i(rego), .clr_i(clr),
`ifdef REG_SBF_INJECT_EN
        .inj_i(inj),
`endif
        .error_o(error_o), .lane_err_o(lane_err_o), .sticky_o(sticky_o),
        .first_lane_o(first_lane_o), .err_cnt_o(err_cnt_o)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference model: parity memory, armed flag, sticky flag, first lane, event count
    bit          m_valid;
    bit [NL-1:0] m_par;
    bit          m_sticky;
    int          m_first;
    int          m_cnt;
    bit          m_prev;

    function automatic void m_reset();
        m_valid = 0; m_par = '0; m_sticky = 0; m_first = 0; m_cnt = 0; m_prev = 0;
    endfunction

    function automatic int par_of(input logic [IW-1:0] v, input int k);
        logic [LW-1:0] lane;
        lane = v[k*LW +: LW];
        return $countones(lane) % 2;
    endfunction

    function automatic bit [NL-1:0] m_mism();
        bit [NL-1:0] r;
        r = '0;
        if (m_valid && en) begin
            for (int k = 0; k < NL; k++) begin
                if (par_of(rego, k) != int'(m_par[k])) r[k] = 1'b1;
            end
        end
        return r;
    endfunction

    function automatic int lowest(input bit [NL-1:0] m);
        for (int k = 0; k < NL; k++) begin
            if (m[k]) return k;
        end
        return 0;
    endfunction

    task automatic step();
        bit [NL-1:0] mm;
        bit e, ev, ib;
        @(negedge clk);
        mm = m_mism();
        e  = |mm;
        chk_eq("lane_err", 32'(lane_err_o), 32'(mm));
        chk_eq("error", 32'(error_o), 32'(e));
        chk_eq("sticky", 32'(sticky_o), 32'(m_sticky));
        chk_eq("first_lane", 32'(first_lane_o), 32'(m_first));
        chk_eq("err_cnt", 32'(err_cnt_o), 32'(m_cnt));
        if (rst) begin
            m_reset();
        end else begin
            ev = e && !m_prev;
            m_prev = e;
            if (clr) m_cnt = ev ? 1 : 0;
            else if (ev && m_cnt < CMAX) m_cnt = m_cnt + 1;
            if (!m_sticky) begin
                if (e) begin
                    m_sticky = 1; m_first = lowest(mm);
                end else if (clr) begin
                    m_first = 0;
                end
            end else if (clr) begin
                if (e) m_first = lowest(mm);
                else begin
                    m_sticky = 0; m_first = 0;
                end
            end
            if (we) begin
                m_valid = 1;
                for (int k = 0; k < NL; k++) begin
`ifdef REG_SBF_INJECT_EN
                    ib = inj[k];
`else
                    ib = 0;
`endif
                    m_par[k] = bit'(par_of(regi, k)) ^ ib;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    logic [IW-1:0] held;
    int            saved_cnt;

    initial begin
        rst = 1; en = 1; we = 0; clr = 0; regi = '0; rego = '0; inj = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_eq("rst_error", 32'(error_o), 0);
        chk_eq("rst_lane", 32'(lane_err_o), 0);
        chk_eq("rst_sticky", 32'(sticky_o), 0);
        chk_eq("rst_first", 32'(first_lane_o), 0);
        chk_eq("rst_cnt", 32'(err_cnt_o), 0);
        rst = 0;
        m_reset();

        // INIT guard
        rego = 32'hFFFF_FFFF;
        #1;
        chk_eq("init_error", 32'(error_o), 0);
        step(); step();
        chk_eq("init_sticky", 32'(sticky_o), 0);

        // Load then single flip in lane 1
        we = 1; regi = 32'h0000_0001; step();
        we = 0; rego = 32'h0000_0001;
        #1;
        chk_eq("load_noerr", 32'(error_o), 0);
        step();
        rego = 32'h0000_0101;
        #1;
        chk_eq("flip_lane", 32'(lane_err_o), 32'h2);
        chk_eq("flip_error", 32'(error_o), 1);
        step();
        chk_eq("flip_sticky", 32'(sticky_o), 1);
        chk_eq("flip_first", 32'(first_lane_o), 1);
        chk_eq("flip_cnt", 32'(err_cnt_o), 1);

        // Persistent flip counts once, re-application counts again
        repeat (9) step();
        rego = 32'h0000_0001; step();
        rego = 32'h0000_0101; step();
        chk_eq("reapply_cnt", 32'(err_cnt_o), 2);
        chk_eq("reapply_first", 32'(first_lane_o), 1);
        rego = 32'h0000_0001; clr = 1; step();
        clr = 0;
        chk_eq("clr_sticky", 32'(sticky_o), 0);
        chk_eq("clr_cnt", 32'(err_cnt_o), 0);

        // Saturation then clear coincident with an event
        for (int i = 0; i < 5; i++) begin
            rego = 32'h0000_0101; step();
            rego = 32'h0000_0001; step();
        end
        chk_eq("sat_cnt", 32'(err_cnt_o), CMAX);
        rego = 32'h0000_0101; clr = 1; step();
        clr = 0;
        chk_eq("clr_ev_cnt", 32'(err_cnt_o), 1);
        chk_eq("clr_ev_sticky", 32'(sticky_o), 1);
        chk_eq("clr_ev_first", 32'(first_lane_o), 1);

        // Multi-lane flip, enable masking, reset from ERR
        rego = 32'h0000_0001; clr = 1; step();
        clr = 0;
        rego = 32'h0101_0001; step();
        chk_eq("multi_first", 32'(first_lane_o), 2);
        rego = 32'h0000_0001; step();
        saved_cnt = int'(err_cnt_o);
        en = 0; rego = 32'h0101_0001;
        #1;
        chk_eq("en0_error", 32'(error_o), 0);
        repeat (3) step();
        chk_eq("en0_cnt", 32'(err_cnt_o), 32'(saved_cnt));
        en = 1; step();
        chk_eq("en1_sticky", 32'(sticky_o), 1);
        rst = 1; step();
        rst = 0;
        chk_eq("rst_err_error", 32'(error_o), 0);
        chk_eq("rst_err_sticky", 32'(sticky_o), 0);
        chk_eq("rst_err_first", 32'(first_lane_o), 0);
        chk_eq("rst_err_cnt", 32'(err_cnt_o), 0);

`ifdef REG_SBF_INJECT_EN
        we = 1; regi = 32'h1234_5678; inj = 4'b1000; rego = '0; step();
        we = 0; inj = '0; rego = 32'h1234_5678;
        #1;
        chk_eq("inj_lane", 32'(lane_err_o), 32'h8);
        step();
`endif

        // Randomized phase
        held = regi;
        for (int c = 0; c < 600; c++) begin
            rst  = ($urandom_range(0, 99) == 0);
            we   = ($urandom_range(0, 5) == 0);
            en   = ($urandom_range(0, 7) != 0);
            clr  = ($urandom_range(0, 11) == 0);
            regi = $urandom;
            inj  = ($urandom_range(0, 3) == 0) ? NL'($urandom) : '0;
            rego = held;
            case ($urandom_range(0, 3))
                0: rego = held ^ (IW'(1) << $urandom_range(0, IW - 1));
                1: rego = held ^ (IW'(1) << $urandom_range(0, IW - 1))
                              ^ (IW'(1) << $urandom_range(0, IW - 1));
                default: rego = held;
            endcase
            step();
            if (we) held = regi;
        end
        rst = 0; we = 0; clr = 0;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
